seq_shift_add_multiplier: RTL

//  Parametrised unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, one shift-add step per clock.

---
 rtl/seq_shift_add_multiplier_pkg.sv | 24 ++
 rtl/seq_shift_add_multiplier_datapath.sv | 55 +++++
 rtl/seq_shift_add_multiplier.sv | 94 +++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_datapath.sv
// Shift-add datapath: multiplicand/multiplier/accumulator registers and the adder.
// acc_next_o is the accumulator value including the current step's add.
module shift_add_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_next_o,
  output logic                 mplier_zero_next_o
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  // Product fits in 2*WIDTH bits, so the add needs no carry-out.
  always_comb begin
    acc_next_o         = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_zero_next_o = ((mplier_q >> 1) == {WIDTH{1'b0}});
    mcand_d            = mcand_q;
    mplier_d           = mplier_q;
    acc_d              = acc_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = {2*WIDTH{1'b0}};
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_next_o;
    end else begin
      acc_d    = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= {2*WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {2*WIDTH{1'b0}};
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH unsigned multiplier with start/busy/done handshake.
// Optional macro MULT_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   y
);

  localparam int CNT_W = clog2(WIDTH + 1);
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               load_s, step_s, last_step_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic               mplier_zero_next_s;

  shift_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk                (clk),
    .rst                (rst),
    .load_i             (load_s),
    .step_i             (step_s),
    .a_i                (A),
    .b_i                (B),
    .acc_next_o         (acc_next_s),
    .mplier_zero_next_o (mplier_zero_next_s)
  );

  assign last_step_s = (cnt_q == CNT_W'(1)) || (EARLY_EXIT && mplier_zero_next_s);

  // Next-state, counter and product-capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (last_step_s) begin
          y_d     = acc_next_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and product registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      y_q     <= {2*WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign y    = y_q;

endmodule
